// File: rtl/prog_loader_pkg.sv
// Shared widths, state encoding and small helpers for the program loader.
package prog_loader_pkg;

  localparam int ROM_ADDR_WIDTH   = 8;
  localparam int ROM_DATA_WIDTH   = 16;
  localparam int LOADER_LEN_BYTES = 2;

  typedef enum logic [2:0] {
    LOADER_ST_LEN_HI = 3'd0,
    LOADER_ST_LEN_LO = 3'd1,
    LOADER_ST_DATA   = 3'd2,
    LOADER_ST_CHECK  = 3'd3,
    LOADER_ST_RUN    = 3'd4,
    LOADER_ST_ERR    = 3'd5
  } loader_state_e;

  // The loader takes host bytes only while a frame is being received.
  function automatic logic loader_accepts(input loader_state_e st);
    case (st)
      LOADER_ST_LEN_HI, LOADER_ST_LEN_LO,
      LOADER_ST_DATA,   LOADER_ST_CHECK: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame,
// writes the assembled instruction words to memory and releases the core
// only after a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = ROM_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       start,
  output logic [INST_ADDR_WIDTH-1:0] prog_addr,
  output logic [INST_DATA_WIDTH-1:0] prog_data,
  output logic                       prog_we,
  output logic                       core_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int BYTES_PER_WORD = INST_DATA_WIDTH / 8;
  localparam int LEN_W          = LOADER_LEN_BYTES * 8;
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BYTES_PER_WORD - 1);
  // Largest legal word count is the full memory depth, 2^INST_ADDR_WIDTH.
  localparam logic [LEN_W:0]    MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << INST_ADDR_WIDTH;

  loader_state_e              r_state;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_word_cnt;
  logic [BIDX_W-1:0]          r_byte_idx;
  logic [INST_DATA_WIDTH-1:0] r_asm;
  logic [7:0]                 r_csum;
  logic [INST_ADDR_WIDTH-1:0] r_prog_addr;
  logic [INST_DATA_WIDTH-1:0] r_prog_data;
  logic                       r_prog_we;
  logic                       r_core_rst;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_error;

  logic                       w_xfer;
  logic [7:0]                 w_csum_next;
  logic [LEN_W-1:0]           w_len_next;
  logic                       w_len_too_big;
  logic [LEN_W-1:0]           w_word_cnt_inc;
  logic [INST_DATA_WIDTH-1:0] w_word;

  assign s_ready        = loader_accepts(r_state);
  assign w_xfer         = s_valid && s_ready;
  assign w_csum_next    = r_csum ^ s_data;
  assign w_len_next     = {r_len[LEN_W-1:8], s_data};
  assign w_len_too_big  = ({1'b0, w_len_next} > MAX_WORDS);
  assign w_word_cnt_inc = r_word_cnt + LEN_W'(1);

  // Word assembly: shift the incoming byte in at the LSB end (big-endian words).
  always_comb begin
    w_word      = r_asm << 8;
    w_word[7:0] = s_data;
  end

  // Loader FSM with counters, checksum accumulator and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= LOADER_ST_LEN_HI;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_byte_idx  <= '0;
      r_asm       <= '0;
      r_csum      <= 8'h00;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_we   <= 1'b0;
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_prog_we <= 1'b0;
      case (r_state)
        LOADER_ST_LEN_HI: begin
          if (w_xfer) begin
            r_len[LEN_W-1:8] <= s_data;
            r_csum           <= w_csum_next;
            r_state          <= LOADER_ST_LEN_LO;
          end
        end
        LOADER_ST_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= s_data;
            r_csum     <= w_csum_next;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            if (w_len_too_big) begin
              r_state <= LOADER_ST_ERR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_len_next == '0) begin
              r_state <= LOADER_ST_CHECK;
            end else begin
              r_state <= LOADER_ST_DATA;
            end
          end
        end
        LOADER_ST_DATA: begin
          if (w_xfer) begin
            r_csum <= w_csum_next;
            r_asm  <= w_word;
            if (r_byte_idx == LAST_BIDX) begin
              r_prog_we   <= 1'b1;
              r_prog_addr <= r_word_cnt[INST_ADDR_WIDTH-1:0];
              r_prog_data <= w_word;
              r_byte_idx  <= '0;
              r_word_cnt  <= w_word_cnt_inc;
              if (w_word_cnt_inc == r_len) begin
                r_state <= LOADER_ST_CHECK;
              end
            end else begin
              r_byte_idx <= r_byte_idx + BIDX_W'(1);
            end
          end
        end
        LOADER_ST_CHECK: begin
          if (w_xfer) begin
            r_csum <= w_csum_next;
            r_busy <= 1'b0;
            if (w_csum_next == 8'h00) begin
              r_state    <= LOADER_ST_RUN;
              r_core_rst <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= LOADER_ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        LOADER_ST_RUN, LOADER_ST_ERR: begin
          if (start) begin
            r_state    <= LOADER_ST_LEN_HI;
            r_csum     <= 8'h00;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: park safely with the core held in reset.
          r_state    <= LOADER_ST_ERR;
          r_core_rst <= 1'b1;
          r_done     <= 1'b0;
          r_error    <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign prog_addr = r_prog_addr;
  assign prog_data = r_prog_data;
  assign prog_we   = r_prog_we;
  assign core_rst  = r_core_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random frames compared
// against a frame-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        start;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        prog_we;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .arst(arst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    int          c;
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  int         cyc = 0;
  wr_t        wlog[$];
  logic [7:0] frame[$];
  int         acc[$];
  int         n_err = 0;
  int         n_chk = 0;

  // Rising-edge counter used to timestamp accepted bytes and writes.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write cycle as seen between clock edges.
  always @(negedge clk) begin
    if (prog_we === 1'b1) wlog.push_back('{cyc, prog_addr, prog_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_prog_we", {31'd0, prog_we}, 32'd0);
    chk("rst_prog_addr", {24'd0, prog_addr}, 32'd0);
    chk("rst_prog_data", {16'd0, prog_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
  endtask

  // Present frame bytes on the handshake; called and returning at a falling edge.
  task automatic send(input bit throttle);
    acc.delete();
    foreach (frame[i]) begin
      int   gap;
      int   budget;
      logic r0;
      if (throttle) begin
        gap = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 2));
        repeat (gap) begin
          s_valid = 1'b0;
          s_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      s_data  = frame[i];
      s_valid = 1'b0;
      #1 r0 = s_ready;
      s_valid = 1'b1;
      #1;
      if (throttle) chk("s_ready_indep_of_valid", {31'd0, s_ready}, {31'd0, r0});
      budget = 20;
      while (budget > 0 && s_ready !== 1'b1) begin
        @(negedge clk);
        budget--;
      end
      if (s_ready !== 1'b1) break;
      acc.push_back(cyc + 1);
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Send the current frame and compare against the frame-level model.
  task automatic run_frame(input bit throttle);
    int         n;
    int         need;
    int         wbase;
    bit         over;
    bit         ok;
    logic [7:0] x;
    wbase = wlog.size();
    send(throttle);
    n    = {frame[0], frame[1]};
    over = (n > 256);
    x    = 8'h00;
    foreach (frame[k]) x ^= frame[k];
    ok   = !over && (x == 8'h00);
    need = over ? 2 : 2 + 2 * n + 1;
    chk("bytes_accepted", acc.size(), need);
    chk("core_rst_after_last", {31'd0, core_rst}, ok ? 32'd0 : 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("write_count", wlog.size() - wbase, over ? 0 : n);
    for (int k = 0; k < n && !over; k++) begin
      if (wbase + k < wlog.size()) begin
        chk("write_addr", {24'd0, wlog[wbase + k].a}, k & 255);
        chk("write_data", {16'd0, wlog[wbase + k].d}, {16'd0, frame[2 + 2 * k], frame[3 + 2 * k]});
        if (acc.size() > 3 + 2 * k) chk("write_cycle", wlog[wbase + k].c, acc[3 + 2 * k]);
      end
    end
    chk("final_done", {31'd0, done}, {31'd0, ok});
    chk("final_error", {31'd0, error}, {31'd0, !ok});
    chk("final_core_rst", {31'd0, core_rst}, {31'd0, !ok});
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_s_ready", {31'd0, s_ready}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_core_rst", {31'd0, core_rst}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_s_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic good_frame(input logic [7:0] csum);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
  endtask

  task automatic random_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] lhi;
    logic [7:0] llo;
    frame.delete();
    lhi = 8'(n >> 8);
    llo = 8'(n);
    frame.push_back(lhi);
    frame.push_back(llo);
    x = lhi ^ llo;
    for (int i = 0; i < 2 * n && n <= 256; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x ^= b;
    end
    if (n <= 256) frame.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  initial begin
    arst    = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    arst = 1'b0;
    @(negedge clk);

    // Good load, back-to-back bytes.
    good_frame(8'h42);
    run_frame(1'b0);

    // Bad checksum.
    do_start();
    good_frame(8'h43);
    run_frame(1'b0);

    // Oversize length 257.
    do_start();
    frame = '{8'h01, 8'h01};
    run_frame(1'b0);

    // Zero length.
    do_start();
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0);

    // Throttled host.
    do_start();
    good_frame(8'h42);
    run_frame(1'b1);

    // Reset in mid-frame, then a full resend.
    do_start();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34};
    send(1'b0);
    arst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    good_frame(8'h42);
    run_frame(1'b0);

    // Reload after start in RUN, then random frames.
    for (int r = 0; r < 8; r++) begin
      do_start();
      random_frame((r == 5) ? int'($urandom_range(257, 300)) : int'($urandom_range(0, 5)),
                   ($urandom_range(0, 2) == 0));
      run_frame(r[0]);
    end

    // Full-depth load: last write lands at address 0xFF.
    do_start();
    random_frame(256, 1'b0);
    run_frame(1'b0);
    chk("full_depth_last_addr", (wlog.size() > 0) ? {24'd0, wlog[wlog.size() - 1].a} : 32'hFFFF_FFFF, 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
